// File: rtl/step_motor_pkg.sv
// Shared constants and step tables for the dual stepper sequencer.
// STEPMOTOR_HALF_STEP_EN selects the 8-entry half-step table instead of the full-step wave table.
`timescale 1ns/1ps
package step_motor_pkg;

  localparam int COIL_W = 4;

  typedef enum logic {
    DIR_REV = 1'b0,
    DIR_FWD = 1'b1
  } dir_e;

  // Packed tables: entry n lives in slice [n].
  localparam logic [3:0][COIL_W-1:0] FULL_TABLE = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [7:0][COIL_W-1:0] HALF_TABLE = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                                   4'b0110, 4'b0010, 4'b0011, 4'b0001};

`ifdef STEPMOTOR_HALF_STEP_EN
  localparam int TABLE_LEN = 8;
  localparam int IDX_W     = 3;
  localparam logic [TABLE_LEN-1:0][COIL_W-1:0] ACTIVE_TABLE = HALF_TABLE;
`else
  localparam int TABLE_LEN = 4;
  localparam int IDX_W     = 2;
  localparam logic [TABLE_LEN-1:0][COIL_W-1:0] ACTIVE_TABLE = FULL_TABLE;
`endif

  function automatic logic [COIL_W-1:0] coilPattern(input logic [IDX_W-1:0] idx);
    return ACTIVE_TABLE[idx];
  endfunction

endpackage

// File: rtl/step_motor_phase.sv
// One stepper channel: phase index register plus registered coil pattern.
// Table length follows STEPMOTOR_HALF_STEP_EN through step_motor_pkg.
`timescale 1ns/1ps
module step_motor_phase
  import step_motor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dir,
  output logic [COIL_W-1:0] coil
);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [COIL_W-1:0] coil_q;

  // Index width equals log2 of the table length, so plain add/subtract wraps both ways.
  always_comb begin
    idx_d = idx_q;
    if (dir == DIR_FWD) idx_d = idx_q + IDX_W'(1);
    else                idx_d = idx_q - IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      coil_q <= '0;
    end else begin
      idx_q  <= idx_d;
      coil_q <= coilPattern(idx_d);
    end
  end

  assign coil = coil_q;

endmodule

// File: rtl/step_motor.sv
// Dual-channel stepper phase sequencer (left/right wheels) clocked by the step-rate clock.
// Define STEPMOTOR_HALF_STEP_EN for half-step drive; default is full-step wave drive.
`timescale 1ns/1ps
module step_motor
  import step_motor_pkg::*;
(
  input  logic              speed,
  input  logic              rst,
  input  logic              dir_left,
  input  logic              dir_right,
  output logic [COIL_W-1:0] motor_left,
  output logic [COIL_W-1:0] motor_right
);

  step_motor_phase u_left (
    .clk  (speed),
    .rst  (rst),
    .dir  (dir_left),
    .coil (motor_left)
  );

  step_motor_phase u_right (
    .clk  (speed),
    .rst  (rst),
    .dir  (dir_right),
    .coil (motor_right)
  );

endmodule

// File: tb/tb_step_motor.sv
// Self-checking bench for step_motor: tracks each wheel as a signed step position
// and derives the expected coil pattern from it. Honors STEPMOTOR_HALF_STEP_EN.
`timescale 1ns/1ps
module tb_step_motor;

  logic       speed;
  logic       rst;
  logic       dirLeft;
  logic       dirRight;
  logic [3:0] motorLeft;
  logic [3:0] motorRight;
  logic       clkRun;

  int checks;
  int errors;
  int posLeft;
  int posRight;
  logic [3:0] prevLeft;
  logic [3:0] prevRight;
  logic       prevValid;

  step_motor dut (
    .speed       (speed),
    .rst         (rst),
    .dir_left    (dirLeft),
    .dir_right   (dirRight),
    .motor_left  (motorLeft),
    .motor_right (motorRight)
  );

  initial speed = 1'b0;
  always #5 if (clkRun) speed = ~speed;

`ifdef STEPMOTOR_HALF_STEP_EN
  localparam int LEN = 8;
`else
  localparam int LEN = 4;
`endif

  // Expected coils from a wheel position: full step lights coil (pos mod 4);
  // half step lights coil k on even positions and coils k and k+1 on odd ones.
  function automatic logic [3:0] modelPattern(input int pos);
    int p;
    int k;
    logic [3:0] pat;
    p = ((pos % LEN) + LEN) % LEN;
`ifdef STEPMOTOR_HALF_STEP_EN
    k = p / 2;
    pat = 4'b0001 << k;
    if (p % 2 == 1) pat = pat | (4'b0001 << ((k + 1) % 4));
`else
    k = p;
    pat = 4'b0001 << k;
`endif
    return pat;
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkBoth(input string tag);
    logic [3:0] expL;
    logic [3:0] expR;
    expL = modelPattern(posLeft);
    expR = modelPattern(posRight);
    checkOutput({tag, "_left"}, motorLeft, expL);
    checkOutput({tag, "_right"}, motorRight, expR);
`ifdef STEPMOTOR_HALF_STEP_EN
    if (prevValid) begin
      checkOutput({tag, "_left_onebit"}, 4'($countones(motorLeft ^ prevLeft)), 4'd1);
      checkOutput({tag, "_right_onebit"}, 4'($countones(motorRight ^ prevRight)), 4'd1);
    end
`else
    checkOutput({tag, "_left_onehot"}, 4'($countones(motorLeft)), 4'd1);
`endif
    prevLeft  = motorLeft;
    prevRight = motorRight;
    prevValid = 1'b1;
  endtask

  // Drive directions, take one rising edge, advance the model, then sample.
  task automatic applyStimulus(input logic dl, input logic dr, input string tag);
    dirLeft  = dl;
    dirRight = dr;
    @(posedge speed);
    posLeft  += dl ? 1 : -1;
    posRight += dr ? 1 : -1;
    #2;
    checkBoth(tag);
  endtask

  // Pulse reset between edges and confirm coils drop without any edge.
  task automatic midRunReset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    checkOutput({tag, "_left"}, motorLeft, 4'b0000);
    checkOutput({tag, "_right"}, motorRight, 4'b0000);
    posLeft   = 0;
    posRight  = 0;
    prevValid = 1'b0;
    @(negedge speed);
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    posLeft   = 0;
    posRight  = 0;
    prevValid = 1'b0;
    prevLeft  = '0;
    prevRight = '0;
    clkRun    = 1'b0;
    rst       = 1'b1;
    dirLeft   = 1'b0;
    dirRight  = 1'b1;

    // Reset held with no clock edges.
    #3;
    checkOutput("reset_noclk_left", motorLeft, 4'b0000);
    checkOutput("reset_noclk_right", motorRight, 4'b0000);

    // Reset held while edges toggle.
    clkRun = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge speed);
      #2;
      checkOutput("reset_clk_left", motorLeft, 4'b0000);
      checkOutput("reset_clk_right", motorRight, 4'b0000);
    end
    @(negedge speed);
    rst = 1'b0;

    // Mirrored straight run.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, "straight");
`ifndef STEPMOTOR_HALF_STEP_EN
    checkOutput("straight_end_left", motorLeft, 4'b0001);
    checkOutput("straight_end_right", motorRight, 4'b0001);
`endif

    // Wrap-around from reset.
    midRunReset("midreset");
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, "wrap");
`ifndef STEPMOTOR_HALF_STEP_EN
    checkOutput("wrap9_left", motorLeft, 4'b1000);
    checkOutput("wrap9_right", motorRight, 4'b0010);
`endif

    // Direction reversal on the right wheel.
    applyStimulus(1'b0, 1'b1, "pre_reverse");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, "reverse");

    // Left toggles every edge while right keeps going forward.
    for (int i = 0; i < 8; i++) applyStimulus(1'((i + 1) % 2), 1'b1, "independence");

    // Randomized run with occasional asynchronous resets.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(39, 0) == 0) midRunReset("rand_reset");
      applyStimulus(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
